// File: rtl/stall_ctrl_if.sv
// Hazard-unit handshake bundle: ID/EX hazard inputs from the pipeline and
// stall/flush/busy controls back to it.
interface stall_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [1:0] id_rs_tuse;
    logic [1:0] id_rt_tuse;
    logic [4:0] id_wa;
    logic [1:0] id_tnew;
    logic       id_md_use;
    logic       ex_md_start;
    logic       ex_md_kind;
    logic       stall;
    logic       flush_idex;
    logic       md_busy;

    modport master (
        output id_rs, id_rt, id_rs_tuse, id_rt_tuse, id_wa, id_tnew,
               id_md_use, ex_md_start, ex_md_kind,
        input  stall, flush_idex, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_rs_tuse, id_rt_tuse, id_wa, id_tnew,
               id_md_use, ex_md_start, ex_md_kind,
        output stall, flush_idex, md_busy
    );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline hazard unit: Tuse/Tnew scoreboard over the EX and MEM stages plus a
// mult/div occupancy counter, producing a zero-latency stall and ID/EX flush.
module stall_ctrl (
    input  logic         clk,
    input  logic         reset,
    stall_ctrl_if.slave  bus
);
    logic [4:0] e_wa_reg;
    logic [1:0] e_tnew_reg;
    logic [4:0] m_wa_reg;
    logic [1:0] m_tnew_reg;
    logic [3:0] md_count_reg;

    logic [4:0] src_reg  [2];
    logic [1:0] src_tuse [2];
    logic [1:0] hazard;
    logic       md_busy;
    logic       stall;

    assign src_reg[0]  = bus.id_rs;
    assign src_tuse[0] = bus.id_rs_tuse;
    assign src_reg[1]  = bus.id_rt;
    assign src_tuse[1] = bus.id_rt_tuse;

    // A source operand stalls when a producer still in flight needs more
    // cycles to deliver than the consumer can wait; $0 and unread operands never do.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign hazard[gi] = (src_reg[gi] != 5'd0) && (src_tuse[gi] != 2'd3) &&
                                (((e_wa_reg == src_reg[gi]) && (e_tnew_reg > src_tuse[gi])) ||
                                 ((m_wa_reg == src_reg[gi]) && (m_tnew_reg > src_tuse[gi])));
        end
    endgenerate

    assign md_busy = bus.ex_md_start || (md_count_reg != 4'd0);
    assign stall   = (|hazard) || (bus.id_md_use && md_busy);

    assign bus.stall      = stall;
    assign bus.flush_idex = stall;
    assign bus.md_busy    = md_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_wa_reg     <= 5'd0;
            e_tnew_reg   <= 2'd0;
            m_wa_reg     <= 5'd0;
            m_tnew_reg   <= 2'd0;
            md_count_reg <= 4'd0;
        end else begin
            // A stalled cycle pushes a bubble into EX; MEM always advances.
            if (stall) begin
                e_wa_reg   <= 5'd0;
                e_tnew_reg <= 2'd0;
            end else begin
                e_wa_reg   <= bus.id_wa;
                e_tnew_reg <= bus.id_tnew;
            end
            m_wa_reg   <= e_wa_reg;
            m_tnew_reg <= (e_tnew_reg == 2'd0) ? 2'd0 : e_tnew_reg - 2'd1;

            // A new start simply reloads, even over an operation still running.
            if (bus.ex_md_start) begin
                md_count_reg <= bus.ex_md_kind ? 4'd10 : 4'd5;
            end else if (md_count_reg != 4'd0) begin
                md_count_reg <= md_count_reg - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed hazard scenarios with literal
// expectations plus a randomized run against an age-based reference model.
module tb_stall_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stall_ctrl_if bus();

    stall_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: what entered EX at the last two edges (age 0 = in EX, age 1 = in MEM),
    // with its original Tnew, and the last cycle index at which mult/div is occupied.
    int   hist_wa   [2];
    int   hist_tnew [2];
    int   cyc     = 0;
    int   md_last = -1;
    logic exp_stall;
    logic exp_busy;

    function automatic int remaining(int age);
        int r;
        r = hist_tnew[age] - age;
        return (r > 0) ? r : 0;
    endfunction

    function automatic bit hz(int r, int tuse);
        if (r == 0 || tuse == 3) return 1'b0;
        for (int age = 0; age < 2; age++)
            if (hist_wa[age] == r && remaining(age) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic got, input logic expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, got, expv);
        end
    endtask

    task automatic drive(input int rs, input int rt, input int rst_u, input int rtt_u,
                         input int wa, input int tnew, input int mduse,
                         input int start, input int kind);
        bus.id_rs       = 5'(rs);
        bus.id_rt       = 5'(rt);
        bus.id_rs_tuse  = 2'(rst_u);
        bus.id_rt_tuse  = 2'(rtt_u);
        bus.id_wa       = 5'(wa);
        bus.id_tnew     = 2'(tnew);
        bus.id_md_use   = 1'(mduse);
        bus.ex_md_start = 1'(start);
        bus.ex_md_kind  = 1'(kind);
    endtask

    task automatic idle();
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
    endtask

    // Mid-cycle: evaluate the model and compare every output.
    task automatic settle();
        #4;
        exp_busy  = bus.ex_md_start || (cyc <= md_last);
        exp_stall = hz(int'(bus.id_rs), int'(bus.id_rs_tuse)) ||
                    hz(int'(bus.id_rt), int'(bus.id_rt_tuse)) ||
                    (bus.id_md_use && exp_busy);
        $display("[TB] cyc %0d rst %b rs %0d/%0d rt %0d/%0d wa %0d/%0d md_use %b start %b kind %b -> stall %b flush %b busy %b",
                 cyc, reset, bus.id_rs, bus.id_rs_tuse, bus.id_rt, bus.id_rt_tuse,
                 bus.id_wa, bus.id_tnew, bus.id_md_use, bus.ex_md_start, bus.ex_md_kind,
                 bus.stall, bus.flush_idex, bus.md_busy);
        chk("stall",      bus.stall,      exp_stall);
        chk("flush_idex", bus.flush_idex, exp_stall);
        chk("md_busy",    bus.md_busy,    exp_busy);
    endtask

    task automatic adv();
        @(posedge clk);
        if (reset) begin
            for (int a = 0; a < 2; a++) begin
                hist_wa[a]   = 0;
                hist_tnew[a] = 0;
            end
            md_last = -1;
        end else begin
            hist_wa[1]   = hist_wa[0];
            hist_tnew[1] = hist_tnew[0];
            hist_wa[0]   = exp_stall ? 0 : int'(bus.id_wa);
            hist_tnew[0] = exp_stall ? 0 : int'(bus.id_tnew);
            if (bus.ex_md_start) md_last = cyc + (bus.ex_md_kind ? 10 : 5);
        end
        cyc++;
        #1;
    endtask

    task automatic cycle();
        settle();
        adv();
    endtask

    initial begin
        for (int a = 0; a < 2; a++) begin
            hist_wa[a]   = 0;
            hist_tnew[a] = 0;
        end
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // Reset state
        settle();
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_busy",  bus.md_busy, 1'b0);
        adv();
        reset = 1'b0;
        cycle();

        // Load-use: lw $1 then addu reading $1 at Tuse 1
        drive(0, 0, 3, 3, 1, 2, 0, 0, 0);
        settle(); chk("lu_producer", bus.stall, 1'b0); adv();
        drive(1, 0, 1, 3, 3, 1, 0, 0, 0);
        settle(); chk("lu_stall", bus.stall, 1'b1); chk("lu_flush", bus.flush_idex, 1'b1); adv();
        settle(); chk("lu_release", bus.stall, 1'b0); adv();
        idle(); cycle(); cycle();

        // ALU result to a branch at Tuse 0, then at Tuse 1
        drive(0, 0, 3, 3, 2, 1, 0, 0, 0); cycle();
        drive(2, 0, 0, 3, 0, 0, 0, 0, 0);
        settle(); chk("ab_stall", bus.stall, 1'b1); adv();
        settle(); chk("ab_release", bus.stall, 1'b0); adv();
        idle(); cycle(); cycle();
        drive(0, 0, 3, 3, 2, 1, 0, 0, 0); cycle();
        drive(0, 2, 3, 1, 0, 0, 0, 0, 0);
        settle(); chk("ab_tuse1", bus.stall, 1'b0); adv();
        idle(); cycle(); cycle();

        // Register 0 is never a hazard
        drive(0, 0, 3, 3, 0, 2, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("zero_e", bus.stall, 1'b0); adv();
        settle(); chk("zero_m", bus.stall, 1'b0); adv();
        idle(); cycle();

        // Divide with a dependent mult/div reader every cycle
        drive(0, 0, 3, 3, 0, 0, 1, 1, 1);
        settle(); chk("div_start_busy", bus.md_busy, 1'b1); chk("div_start_stall", bus.stall, 1'b1); adv();
        drive(0, 0, 3, 3, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            settle(); chk("div_busy", bus.md_busy, 1'b1); chk("div_stall", bus.stall, 1'b1); adv();
        end
        settle(); chk("div_done_busy", bus.md_busy, 1'b0); chk("div_done_stall", bus.stall, 1'b0); adv();
        idle(); cycle();

        // Reload: multiply, then a divide two cycles later
        drive(0, 0, 3, 3, 0, 0, 0, 1, 0); cycle();
        idle(); cycle(); cycle();
        drive(0, 0, 3, 3, 0, 0, 0, 1, 1); cycle();
        idle();
        for (int i = 0; i < 10; i++) begin
            settle(); chk("reload_busy", bus.md_busy, 1'b1); adv();
        end
        settle(); chk("reload_done", bus.md_busy, 1'b0); adv();

        // Reset with a divide at count 6 and a load in the scoreboard
        drive(0, 0, 3, 3, 5, 2, 0, 1, 1); cycle();
        drive(0, 0, 3, 3, 5, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        settle(); chk("mid_div_busy", bus.md_busy, 1'b1);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        drive(5, 5, 0, 0, 0, 0, 1, 0, 0);
        settle(); chk("post_rst_busy", bus.md_busy, 1'b0); chk("post_rst_stall", bus.stall, 1'b0); adv();
        idle(); cycle();

        // Randomized traffic over a small register window to provoke matches
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                  $urandom_range(0, 1));
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
